// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO with occupancy thresholds and sticky error flags.
// Supports a registered read mode or a first-word-fall-through read mode.
module param_sync_fifo #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3,
    parameter int AF_LVL = 6,
    parameter int AE_LVL = 2,
    parameter int FWFT   = 0
) (
    input  logic              slow_clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] data_in,
    input  logic              rd_en,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              overflow,
    output logic              underflow,
    input  logic              err_clr,
    output logic [ADDR_W:0]   count
);

    localparam int              DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] LP_DEPTH  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] LP_AF     = (ADDR_W + 1)'(AF_LVL);
    localparam logic [ADDR_W:0] LP_AE     = (ADDR_W + 1)'(AE_LVL);
    localparam logic [ADDR_W:0] LP_ONE    = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] LP_PINC = ADDR_W'(1);

    if (DEPTH < 2) begin : g_bad_depth
        $error("param_sync_fifo: DEPTH must be at least 2");
    end
    if (AE_LVL >= AF_LVL) begin : g_bad_levels
        $error("param_sync_fifo: AE_LVL must be below AF_LVL");
    end
    if (AF_LVL < 1 || AF_LVL > DEPTH || AE_LVL < 0 || AE_LVL > DEPTH - 1) begin : g_bad_range
        $error("param_sync_fifo: AF_LVL/AE_LVL out of range");
    end

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_overflow;
    logic              r_underflow;
    logic              w_wr_acc;
    logic              w_rd_acc;

    assign full         = (r_count == LP_DEPTH);
    assign empty        = (r_count == '0);
    assign almost_full  = (r_count >= LP_AF);
    assign almost_empty = (r_count <= LP_AE);
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    assign w_wr_acc = wr_en & ~full;
    assign w_rd_acc = rd_en & ~empty;

    // NOTE: storage has no reset; a reset only empties the FIFO via the pointers and count.
    always_ff @(posedge slow_clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every reader sees pre-edge values.
    always_ff @(posedge slow_clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + LP_PINC;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + LP_PINC;
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + LP_ONE;
                2'b01:   r_count <= r_count - LP_ONE;
                default: r_count <= r_count;
            endcase
            // A new error event takes priority over a coincident clear.
            if (wr_en && full) begin
                r_overflow <= 1'b1;
            end else if (err_clr) begin
                r_overflow <= 1'b0;
            end
            if (rd_en && empty) begin
                r_underflow <= 1'b1;
            end else if (err_clr) begin
                r_underflow <= 1'b0;
            end
        end
    end

    if (FWFT != 0) begin : g_fwft
        assign data_out = r_mem[r_rd_ptr];
        assign rd_valid = ~empty;
    end else begin : g_std
        logic [DATA_W-1:0] r_data_out;
        logic              r_rd_valid;

        always_ff @(posedge slow_clk or posedge rst) begin
            if (rst) begin
                r_data_out <= '0;
                r_rd_valid <= 1'b0;
            end else begin
                r_rd_valid <= w_rd_acc;
                if (w_rd_acc) begin
                    r_data_out <= r_mem[r_rd_ptr];
                end
            end
        end

        assign data_out = r_data_out;
        assign rd_valid = r_rd_valid;
    end

endmodule

// File: tb/tb_param_sync_fifo.sv
// Self-checking bench: a registered-read and an FWFT instance share one stimulus stream and
// are compared every cycle against a queue-based model, plus directed literal checks.
module tb_param_sync_fifo;

    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 2;

    logic          slow_clk = 1'b0;
    logic          rst      = 1'b1;
    logic          wr_en    = 1'b0;
    logic          rd_en    = 1'b0;
    logic          err_clr  = 1'b0;
    logic [DW-1:0] data_in  = '0;

    logic [DW-1:0] s_dout, f_dout;
    logic          s_rv, s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
    logic          f_rv, f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
    logic [AW:0]   s_cnt, f_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    logic [DW-1:0] q[$];
    logic [DW-1:0] m_dout = '0;
    logic          m_rv   = 1'b0;
    logic          m_ovf  = 1'b0;
    logic          m_udf  = 1'b0;

    always #5 slow_clk = ~slow_clk;

    param_sync_fifo #(.DATA_W(DW), .ADDR_W(AW), .AF_LVL(AF), .AE_LVL(AE), .FWFT(0)) dut (
        .slow_clk(slow_clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .data_out(s_dout), .rd_valid(s_rv), .full(s_full), .empty(s_empty),
        .almost_full(s_af), .almost_empty(s_ae), .overflow(s_ovf), .underflow(s_udf),
        .err_clr(err_clr), .count(s_cnt)
    );

    param_sync_fifo #(.DATA_W(DW), .ADDR_W(AW), .AF_LVL(AF), .AE_LVL(AE), .FWFT(1)) dut_fw (
        .slow_clk(slow_clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .data_out(f_dout), .rd_valid(f_rv), .full(f_full), .empty(f_empty),
        .almost_full(f_af), .almost_empty(f_ae), .overflow(f_ovf), .underflow(f_udf),
        .err_clr(err_clr), .count(f_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_dout = '0;
        m_rv   = 1'b0;
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
    endtask

    // Model of one clock edge, decided from the pre-edge occupancy.
    task automatic model_edge(input logic w, input logic [DW-1:0] d, input logic r, input logic ec);
        int  n;
        bit  w_ok, r_ok;
        n    = q.size();
        w_ok = w && (n < DEPTH);
        r_ok = r && (n > 0);
        if (w && n == DEPTH) m_ovf = 1'b1;
        else if (ec)         m_ovf = 1'b0;
        if (r && n == 0)     m_udf = 1'b1;
        else if (ec)         m_udf = 1'b0;
        m_rv = r_ok;
        if (r_ok) m_dout = q.pop_front();
        if (w_ok) q.push_back(d);
    endtask

    task automatic step(input logic w, input logic [DW-1:0] d, input logic r, input logic ec);
        wr_en   = w;
        data_in = d;
        rd_en   = r;
        err_clr = ec;
        @(posedge slow_clk);
        model_edge(w, d, r, ec);
        @(negedge slow_clk);
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, 1'b0);
    endtask

    always @(negedge slow_clk) begin
        if (chk_en && !rst) begin
            int n;
            n = q.size();
            check("std_count", s_cnt, n);
            check("std_full",  s_full,  n == DEPTH);
            check("std_empty", s_empty, n == 0);
            check("std_af",    s_af,    n >= AF);
            check("std_ae",    s_ae,    n <= AE);
            check("std_ovf",   s_ovf,   m_ovf);
            check("std_udf",   s_udf,   m_udf);
            check("std_rv",    s_rv,    m_rv);
            check("std_dout",  s_dout,  m_dout);
            check("fw_count",  f_cnt,   n);
            check("fw_flags",  {f_full, f_empty, f_af, f_ae},
                  {n == DEPTH, n == 0, n >= AF, n <= AE});
            check("fw_err",    {f_ovf, f_udf}, {m_ovf, m_udf});
            check("fw_rv",     f_rv,    n != 0);
            if (n != 0) check("fw_dout", f_dout, q[0]);
        end
    end

    initial begin
        logic [DW-1:0] v;
        int            wp;

        repeat (2) @(posedge slow_clk);
        @(negedge slow_clk);
        check("rst_count", s_cnt, 0);
        check("rst_empty", s_empty, 1);
        check("rst_full",  s_full, 0);
        check("rst_ae",    s_ae, 1);
        check("rst_af",    s_af, 0);
        check("rst_err",   {s_ovf, s_udf}, 0);
        check("rst_dout",  s_dout, 0);
        check("rst_rv",    s_rv, 0);
        check("rst_fw_rv", f_rv, 0);
        rst    = 1'b0;
        chk_en = 1'b1;

        // Fill and drain in order.
        for (int i = 1; i <= 8; i++) step(1'b1, DW'(8'h11 * i), 1'b0, 1'b0);
        check("fill_full",  s_full, 1);
        check("fill_count", s_cnt, 8);
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            check("drain_rv",   s_rv, 1);
            check("drain_data", s_dout, 8'h11 * i);
        end
        check("drain_empty", s_empty, 1);
        idle();
        check("rv_pulse_end", s_rv, 0);
        check("dout_hold",    s_dout, 8'h88);

        // Thresholds.
        step(1'b1, 8'h01, 1'b0, 1'b0);
        step(1'b1, 8'h02, 1'b0, 1'b0);
        check("thr_ae_at2", s_ae, 1);
        step(1'b1, 8'h03, 1'b0, 1'b0);
        check("thr_ae_at3", s_ae, 0);
        step(1'b1, 8'h04, 1'b0, 1'b0);
        step(1'b1, 8'h05, 1'b0, 1'b0);
        check("thr_af_at5", s_af, 0);
        step(1'b1, 8'h06, 1'b0, 1'b0);
        check("thr_af_at6", s_af, 1);
        repeat (6) step(1'b0, '0, 1'b1, 1'b0);

        // Collision at full: read wins, 0xAA dropped.
        for (int i = 1; i <= 8; i++) step(1'b1, DW'(i), 1'b0, 1'b0);
        step(1'b1, 8'hAA, 1'b1, 1'b0);
        check("colf_count", s_cnt, 7);
        check("colf_ovf",   s_ovf, 1);
        check("colf_data",  s_dout, 8'h01);
        for (int i = 2; i <= 8; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            check("colf_drain", s_dout, i);
        end
        // Collision at empty: write wins.
        step(1'b1, 8'h55, 1'b1, 1'b0);
        check("cole_count", s_cnt, 1);
        check("cole_udf",   s_udf, 1);
        check("cole_rv",    s_rv, 0);
        step(1'b0, '0, 1'b1, 1'b0);
        check("cole_data",  s_dout, 8'h55);
        // Set wins over a coincident clear, then a plain clear.
        step(1'b0, '0, 1'b1, 1'b1);
        check("clr_setwins_udf", s_udf, 1);
        check("clr_setwins_ovf", s_ovf, 0);
        step(1'b0, '0, 1'b0, 1'b1);
        check("clr_udf", s_udf, 0);

        // Wrap with count held at 3.
        wp = 0;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, DW'(8'hA0 + wp), 1'b0, 1'b0);
            wp++;
        end
        for (int i = 0; i < 20; i++) begin
            step(1'b1, DW'(8'hA0 + wp), 1'b1, 1'b0);
            wp++;
            check("wrap_data",  s_dout, 8'hA0 + i);
            check("wrap_count", s_cnt, 3);
        end
        repeat (3) step(1'b0, '0, 1'b1, 1'b0);
        check("wrap_last", s_dout, 8'hA0 + 22);

        // Overflow then clear.
        for (int i = 0; i < 9; i++) step(1'b1, DW'(8'hC0 + i), 1'b0, 1'b0);
        check("ovf_set", s_ovf, 1);
        step(1'b0, '0, 1'b0, 1'b1);
        check("ovf_clr", s_ovf, 0);
        repeat (3) step(1'b0, '0, 1'b1, 1'b0);
        check("pre_rst_count", s_cnt, 5);

        // Asynchronous reset mid-burst, checked between clock edges.
        wr_en   = 1'b1;
        data_in = 8'hEE;
        #2;
        rst = 1'b1;
        model_clear();
        #1;
        check("arst_count", s_cnt, 0);
        check("arst_empty", s_empty, 1);
        check("arst_dout",  s_dout, 0);
        check("arst_fw_cnt", f_cnt, 0);
        wr_en = 1'b0;
        @(posedge slow_clk);
        @(negedge slow_clk);
        rst = 1'b0;

        // FWFT head presentation.
        step(1'b1, 8'h3C, 1'b0, 1'b0);
        check("fwft_dout", f_dout, 8'h3C);
        check("fwft_rv",   f_rv, 1);
        step(1'b0, '0, 1'b1, 1'b0);
        check("fwft_rv_pop", f_rv, 0);

        // Randomised traffic with alternating fill-biased and drain-biased phases.
        for (int i = 0; i < 800; i++) begin
            int pw;
            pw = ((i / 40) % 2 == 0) ? 75 : 25;
            v  = DW'($urandom);
            step($urandom_range(0, 99) < pw, v, $urandom_range(0, 99) < (100 - pw),
                 $urandom_range(0, 15) == 0);
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
